// File: rtl/d_e_reg_if.sv
// Bundle of the D->E pipeline register: D-stage inputs, M/W forward sources, stall controls and E outputs.
// Statistics outputs exist only when DE_STAT_EN is defined.
interface d_e_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          bubble;
    logic          flush;
    logic          hold;
    logic [DW-1:0] D_PC;
    logic [DW-1:0] D_Instr;
    logic [DW-1:0] D_RS_Data;
    logic [DW-1:0] D_RT_Data;
    logic [RW-1:0] D_RS_Addr;
    logic [RW-1:0] D_RT_Addr;
    logic [DW-1:0] D_EXT;
    logic [3:0]    D_ALUOp;
    logic          D_ALUSrc;
    logic          D_RegWrite;
    logic [RW-1:0] D_WriteReg;
    logic [1:0]    D_Tnew;
    logic          M_RegWrite;
    logic [RW-1:0] M_WriteReg;
    logic [DW-1:0] M_FwdData;
    logic          W_RegWrite;
    logic [RW-1:0] W_WriteReg;
    logic [DW-1:0] W_FwdData;
    logic [DW-1:0] E_PC;
    logic [DW-1:0] E_Instr;
    logic [DW-1:0] E_EXT;
    logic [3:0]    E_ALUOp;
    logic          E_RegWrite;
    logic [RW-1:0] E_WriteReg;
    logic [RW-1:0] E_RS_Addr;
    logic [RW-1:0] E_RT_Addr;
    logic [1:0]    E_Tnew;
    logic [1:0]    E_Tnew_M;
    logic          E_Valid;
    logic [DW-1:0] Src_A;
    logic [DW-1:0] Src_B;
    logic [DW-1:0] E_RT_Fwd;
`ifdef DE_STAT_EN
    logic [31:0]   stat_bubbles;
    logic [31:0]   stat_fwd_m;
    logic [31:0]   stat_fwd_w;
`endif

    modport master (
        output bubble, flush, hold, D_PC, D_Instr, D_RS_Data, D_RT_Data, D_RS_Addr, D_RT_Addr,
               D_EXT, D_ALUOp, D_ALUSrc, D_RegWrite, D_WriteReg, D_Tnew,
               M_RegWrite, M_WriteReg, M_FwdData, W_RegWrite, W_WriteReg, W_FwdData,
        input  E_PC, E_Instr, E_EXT, E_ALUOp, E_RegWrite, E_WriteReg, E_RS_Addr, E_RT_Addr,
               E_Tnew, E_Tnew_M, E_Valid, Src_A, Src_B, E_RT_Fwd
`ifdef DE_STAT_EN
        , input stat_bubbles, stat_fwd_m, stat_fwd_w
`endif
    );

    modport slave (
        input  bubble, flush, hold, D_PC, D_Instr, D_RS_Data, D_RT_Data, D_RS_Addr, D_RT_Addr,
               D_EXT, D_ALUOp, D_ALUSrc, D_RegWrite, D_WriteReg, D_Tnew,
               M_RegWrite, M_WriteReg, M_FwdData, W_RegWrite, W_WriteReg, W_FwdData,
        output E_PC, E_Instr, E_EXT, E_ALUOp, E_RegWrite, E_WriteReg, E_RS_Addr, E_RT_Addr,
               E_Tnew, E_Tnew_M, E_Valid, Src_A, Src_B, E_RT_Fwd
`ifdef DE_STAT_EN
        , output stat_bubbles, stat_fwd_m, stat_fwd_w
`endif
    );
endinterface

// File: rtl/d_e_reg.sv
// Decode-to-Execute pipeline register with bubble/flush/hold and M/W operand forwarding.
// Optional DE_STAT_EN adds bubble and forwarding-source event counters.
module d_e_reg #(
    parameter int            DW     = 32,
    parameter int            RW     = 5,
    parameter logic [DW-1:0] PC_RST = 32'h0000_3000
) (
    input  logic     clk,
    input  logic     reset,
    d_e_reg_if.slave bus
);
    logic [DW-1:0] r_pc, r_instr, r_ext, r_rs_data, r_rt_data;
    logic [RW-1:0] r_rs_addr, r_rt_addr, r_writereg;
    logic [3:0]    r_aluop;
    logic [1:0]    r_tnew;
    logic          r_alusrc, r_regwrite, r_valid;

    logic          w_rs_m, w_rs_w, w_rt_m, w_rt_w;
    logic [DW-1:0] w_src_a, w_rt_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= PC_RST;
            r_instr    <= '0;
            r_ext      <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_writereg <= '0;
            r_aluop    <= '0;
            r_tnew     <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
        end else if (bus.bubble || bus.flush) begin
            // NOP image, but the D PC is kept for exception tracing
            r_pc       <= bus.D_PC;
            r_instr    <= '0;
            r_ext      <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_writereg <= '0;
            r_aluop    <= '0;
            r_tnew     <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!bus.hold) begin
            r_pc       <= bus.D_PC;
            r_instr    <= bus.D_Instr;
            r_ext      <= bus.D_EXT;
            r_rs_data  <= bus.D_RS_Data;
            r_rt_data  <= bus.D_RT_Data;
            r_rs_addr  <= bus.D_RS_Addr;
            r_rt_addr  <= bus.D_RT_Addr;
            r_writereg <= bus.D_WriteReg;
            r_aluop    <= bus.D_ALUOp;
            r_tnew     <= bus.D_Tnew;
            r_alusrc   <= bus.D_ALUSrc;
            r_regwrite <= bus.D_RegWrite;
            r_valid    <= 1'b1;
        end
    end

    // $0 is never forwarded; M takes precedence over W
    always_comb begin
        w_rs_m = (r_rs_addr != '0) && bus.M_RegWrite && (bus.M_WriteReg == r_rs_addr);
        w_rs_w = (r_rs_addr != '0) && !w_rs_m && bus.W_RegWrite && (bus.W_WriteReg == r_rs_addr);
        w_rt_m = (r_rt_addr != '0) && bus.M_RegWrite && (bus.M_WriteReg == r_rt_addr);
        w_rt_w = (r_rt_addr != '0) && !w_rt_m && bus.W_RegWrite && (bus.W_WriteReg == r_rt_addr);

        if (r_rs_addr == '0) w_src_a = '0;
        else if (w_rs_m)     w_src_a = bus.M_FwdData;
        else if (w_rs_w)     w_src_a = bus.W_FwdData;
        else                 w_src_a = r_rs_data;

        if (r_rt_addr == '0) w_rt_fwd = '0;
        else if (w_rt_m)     w_rt_fwd = bus.M_FwdData;
        else if (w_rt_w)     w_rt_fwd = bus.W_FwdData;
        else                 w_rt_fwd = r_rt_data;
    end

    assign bus.E_PC       = r_pc;
    assign bus.E_Instr    = r_instr;
    assign bus.E_EXT      = r_ext;
    assign bus.E_ALUOp    = r_aluop;
    assign bus.E_RegWrite = r_regwrite;
    assign bus.E_WriteReg = r_writereg;
    assign bus.E_RS_Addr  = r_rs_addr;
    assign bus.E_RT_Addr  = r_rt_addr;
    assign bus.E_Tnew     = r_tnew;
    assign bus.E_Tnew_M   = (r_tnew == 2'd0) ? 2'd0 : r_tnew - 2'd1;
    assign bus.E_Valid    = r_valid;
    assign bus.Src_A      = w_src_a;
    assign bus.E_RT_Fwd   = w_rt_fwd;
    assign bus.Src_B      = r_alusrc ? r_ext : w_rt_fwd;

`ifdef DE_STAT_EN
    logic [31:0] r_stat_bubbles, r_stat_fwd_m, r_stat_fwd_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_bubbles <= '0;
            r_stat_fwd_m   <= '0;
            r_stat_fwd_w   <= '0;
        end else begin
            if (bus.bubble || bus.flush)        r_stat_bubbles <= r_stat_bubbles + 32'd1;
            if (r_valid && (w_rs_m || w_rt_m))  r_stat_fwd_m   <= r_stat_fwd_m + 32'd1;
            if (r_valid && (w_rs_w || w_rt_w))  r_stat_fwd_w   <= r_stat_fwd_w + 32'd1;
        end
    end

    assign bus.stat_bubbles = r_stat_bubbles;
    assign bus.stat_fwd_m   = r_stat_fwd_m;
    assign bus.stat_fwd_w   = r_stat_fwd_w;
`endif
endmodule

// File: tb/tb_d_e_reg.sv
// Scoreboard bench for d_e_reg: stimulus queues expected field values, a negedge monitor compares them.
module tb_d_e_reg;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    d_e_reg_if #(.DW(32), .RW(5)) bus ();

    d_e_reg #(.DW(32), .RW(5), .PC_RST(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef enum logic [3:0] {
        F_PC, F_VALID, F_SRCA, F_SRCB, F_ALUOP, F_REGWR, F_WREG,
        F_TNEW, F_TNEWM, F_RTFWD, F_INSTR, F_STATB
    } fld_e;

    typedef struct {
        string       name;
        fld_e        f;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] get(input fld_e f);
        logic [31:0] r;
        r = '0;
        case (f)
            F_PC:    r = bus.E_PC;
            F_VALID: r = {31'd0, bus.E_Valid};
            F_SRCA:  r = bus.Src_A;
            F_SRCB:  r = bus.Src_B;
            F_ALUOP: r = {28'd0, bus.E_ALUOp};
            F_REGWR: r = {31'd0, bus.E_RegWrite};
            F_WREG:  r = {27'd0, bus.E_WriteReg};
            F_TNEW:  r = {30'd0, bus.E_Tnew};
            F_TNEWM: r = {30'd0, bus.E_Tnew_M};
            F_RTFWD: r = bus.E_RT_Fwd;
            F_INSTR: r = bus.E_Instr;
`ifdef DE_STAT_EN
            F_STATB: r = bus.stat_bubbles;
`endif
            default: r = 'x;
        endcase
        return r;
    endfunction

    // monitor: registers settle after the posedge, so sample on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (get(e.f) !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, get(e.f), e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exp_push(input string n, input fld_e f, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.f    = f;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.bubble = 0; bus.flush = 0; bus.hold = 0;
        bus.D_PC = '0; bus.D_Instr = '0; bus.D_RS_Data = '0; bus.D_RT_Data = '0;
        bus.D_RS_Addr = '0; bus.D_RT_Addr = '0; bus.D_EXT = '0; bus.D_ALUOp = '0;
        bus.D_ALUSrc = 0; bus.D_RegWrite = 0; bus.D_WriteReg = '0; bus.D_Tnew = '0;
        bus.M_RegWrite = 0; bus.M_WriteReg = '0; bus.M_FwdData = '0;
        bus.W_RegWrite = 0; bus.W_WriteReg = '0; bus.W_FwdData = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        exp_push("rst_pc",    F_PC,    32'h3000);
        exp_push("rst_valid", F_VALID, 32'd0);
        exp_push("rst_srca",  F_SRCA,  32'd0);
        exp_push("rst_aluop", F_ALUOP, 32'd0);
        exp_push("rst_regwr", F_REGWR, 32'd0);
`ifdef DE_STAT_EN
        exp_push("rst_statb", F_STATB, 32'd0);
`endif
        sync();

        // first load after reset
        reset = 1'b0;
        bus.D_PC = 32'h3004; bus.D_RS_Addr = 5'd1; bus.D_RS_Data = 32'd5;
        bus.D_RT_Addr = 5'd2; bus.D_RT_Data = 32'd7; bus.D_ALUSrc = 0;
        bus.D_ALUOp = 4'd1; bus.D_RegWrite = 1; bus.D_WriteReg = 5'd3; bus.D_Tnew = 2'd2;
        bus.D_Instr = 32'h0000_1234; bus.D_EXT = 32'h10;
        tick();
        exp_push("ld_pc",    F_PC,    32'h3004);
        exp_push("ld_srca",  F_SRCA,  32'd5);
        exp_push("ld_srcb",  F_SRCB,  32'd7);
        exp_push("ld_valid", F_VALID, 32'd1);
        exp_push("ld_aluop", F_ALUOP, 32'd1);
        exp_push("ld_wreg",  F_WREG,  32'd3);
        exp_push("ld_instr", F_INSTR, 32'h0000_1234);
        sync();

        // M/W priority on rs
        bus.D_PC = 32'h3008; bus.D_RS_Addr = 5'd8; bus.D_RS_Data = 32'd1;
        bus.D_RT_Addr = 5'd9; bus.D_RT_Data = 32'd2;
        tick();
        exp_push("fw_none", F_SRCA, 32'd1);
        sync();
        bus.M_RegWrite = 1; bus.M_WriteReg = 5'd8; bus.M_FwdData = 32'hAA;
        bus.W_RegWrite = 1; bus.W_WriteReg = 5'd8; bus.W_FwdData = 32'hBB;
        exp_push("fw_m_over_w", F_SRCA, 32'hAA);
        exp_push("fw_rt_nomatch", F_SRCB, 32'd2);
        sync();
        bus.M_RegWrite = 0;
        exp_push("fw_w_only", F_SRCA, 32'hBB);
        sync();

        // $0 never forwarded
        bus.W_RegWrite = 0;
        bus.D_RS_Addr = 5'd0; bus.D_RS_Data = 32'h77;
        bus.M_RegWrite = 1; bus.M_WriteReg = 5'd0; bus.M_FwdData = 32'h55;
        tick();
        exp_push("fw_zero", F_SRCA, 32'd0);
        sync();

        // hold for 3 cycles while D changes
        bus.M_RegWrite = 0; bus.M_WriteReg = '0;
        bus.D_PC = 32'h300C; bus.D_RS_Addr = 5'd4; bus.D_RS_Data = 32'h40;
        bus.D_RT_Addr = 5'd5; bus.D_RT_Data = 32'h50; bus.D_ALUOp = 4'd2;
        bus.D_WriteReg = 5'd6; bus.D_Tnew = 2'd3; bus.D_Instr = 32'h0000_CAFE;
        tick();
        exp_push("hl_load_pc", F_PC,    32'h300C);
        exp_push("hl_tnew",    F_TNEW,  32'd3);
        exp_push("hl_tnewm3",  F_TNEWM, 32'd2);
        sync();
        bus.hold = 1;
        bus.D_PC = 32'h3FFC; bus.D_RS_Data = 32'd1; bus.D_ALUOp = 4'd0; bus.D_Tnew = 2'd0;
        bus.D_Instr = '0; bus.D_WriteReg = 5'd1; bus.D_RS_Addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_push("hold_pc",    F_PC,    32'h300C);
            exp_push("hold_instr", F_INSTR, 32'h0000_CAFE);
            exp_push("hold_aluop", F_ALUOP, 32'd2);
            exp_push("hold_srca",  F_SRCA,  32'h40);
            exp_push("hold_wreg",  F_WREG,  32'd6);
            exp_push("hold_tnew",  F_TNEW,  32'd3);
            exp_push("hold_valid", F_VALID, 32'd1);
            sync();
        end
        bus.W_RegWrite = 1; bus.W_WriteReg = 5'd5; bus.W_FwdData = 32'h12;
        exp_push("hold_fw_srcb", F_SRCB,  32'h12);
        exp_push("hold_fw_rt",   F_RTFWD, 32'h12);
        sync();

        // bubble wins over hold
        bus.W_RegWrite = 0;
        bus.bubble = 1; bus.D_PC = 32'h3010;
        tick();
        exp_push("bub_valid", F_VALID, 32'd0);
        exp_push("bub_regwr", F_REGWR, 32'd0);
        exp_push("bub_wreg",  F_WREG,  32'd0);
        exp_push("bub_pc",    F_PC,    32'h3010);
        exp_push("bub_aluop", F_ALUOP, 32'd0);
`ifdef DE_STAT_EN
        exp_push("bub_statb", F_STATB, 32'd1);
`endif
        sync();
        bus.bubble = 0; bus.hold = 0;
        bus.flush = 1; bus.D_PC = 32'h3014;
        tick();
        exp_push("fl_valid", F_VALID, 32'd0);
        exp_push("fl_pc",    F_PC,    32'h3014);
`ifdef DE_STAT_EN
        exp_push("fl_statb", F_STATB, 32'd2);
`endif
        sync();
        bus.flush = 0;

        // Tnew decrement and immediate operand
        bus.D_PC = 32'h3018; bus.D_Tnew = 2'd2; bus.D_ALUSrc = 1; bus.D_EXT = 32'hFFFF_FFFC;
        bus.D_RT_Addr = 5'd5; bus.D_RT_Data = 32'd3;
        tick();
        exp_push("tn_tnew2",  F_TNEW,  32'd2);
        exp_push("tn_tnewm2", F_TNEWM, 32'd1);
        exp_push("imm_srcb",  F_SRCB,  32'hFFFF_FFFC);
        exp_push("imm_rtfwd", F_RTFWD, 32'd3);
        sync();
        bus.D_Tnew = 2'd0;
        tick();
        exp_push("tn_tnewm0", F_TNEWM, 32'd0);
        sync();
        bus.D_Tnew = 2'd1;
        tick();
        exp_push("tn_tnewm1", F_TNEWM, 32'd0);
        exp_push("tn_tnew1",  F_TNEW,  32'd1);
        sync();

        repeat (2) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
